// File: rtl/mem_wb_stage_pkg.sv
// Shared widths, control-bit indices and occupancy encodings for the MEM->WB stage.
package mem_wb_stage_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_REG_AW  = 5;
  localparam int DEF_MCTRL_W = 8;
  localparam int DEF_WCTRL_W = 3;

  // Bit of the W control bundle that enables the register-file write.
  localparam int REG_WRITE_BIT = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The main entry drives the output;
// the skid entry absorbs the one beat that arrives after the consumer stalls,
// so the upstream ready can be a flop with no path from out_ready_i.
module pipe_skid_buf
  import mem_wb_stage_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  occ_e             occ_q, occ_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept, emit;

  assign accept      = in_valid_i & ready_q;
  assign emit        = (occ_q != EMPTY) & out_ready_i;
  assign in_ready_o  = ready_q;
  assign out_valid_o = (occ_q != EMPTY);
  assign out_data_o  = main_q;

  // Next occupancy and entry contents; flush drops everything held or arriving.
  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    case (occ_q)
      EMPTY: begin
        if (accept) begin
          occ_d  = FULL1;
          main_d = in_data_i;
        end
      end
      FULL1: begin
        if (accept && emit) begin
          main_d = in_data_i;
        end else if (accept) begin
          occ_d  = FULL2;
          skid_d = in_data_i;
        end else if (emit) begin
          occ_d = EMPTY;
        end
      end
      FULL2: begin
        if (emit) begin
          occ_d  = FULL1;
          main_d = skid_q;
        end
      end
      default: occ_d = EMPTY;
    endcase
    if (flush_i) begin
      occ_d  = EMPTY;
      main_d = main_q;
      skid_d = skid_q;
    end
    ready_d = (occ_d != FULL2);
  end

  // Occupancy, registered ready and entry storage; reset clears data as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      occ_q   <= occ_d;
      ready_q <= ready_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: packs load data, ALU result, destination, sliced
// W control and overflow flag into a skid-buffered handshake. A flagged
// overflow suppresses the register write at capture time.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int REG_AW      = DEF_REG_AW,
  parameter int MCTRL_W     = DEF_MCTRL_W,
  parameter int WCTRL_W     = DEF_WCTRL_W,
  parameter bit KILL_ON_OVF = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               m_valid,
  output logic               m_ready,
  input  logic [DATA_W-1:0]  mem_data_m,
  input  logic [DATA_W-1:0]  alu_out_m,
  input  logic [REG_AW-1:0]  reg_dst_m,
  input  logic [MCTRL_W-1:0] ctrl_m,
  input  logic               ovf_m,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [DATA_W-1:0]  mem_data_w,
  output logic [DATA_W-1:0]  alu_out_w,
  output logic [REG_AW-1:0]  reg_dst_w,
  output logic [WCTRL_W-1:0] ctrl_w,
  output logic               ovf_w
);

  localparam int PAY_W = 2*DATA_W + REG_AW + WCTRL_W + 1;

  logic [WCTRL_W-1:0] ctrl_cap;
  logic [PAY_W-1:0]   pay_in;
  logic [PAY_W-1:0]   pay_out;
  // Upper M-stage control bits have no consumer past this stage.
  logic               unused_ctrl_hi;

  assign unused_ctrl_hi = ^ctrl_m;

  // Keep only the W-stage bits; clear reg_write when overflow kill applies.
  function automatic logic [WCTRL_W-1:0] slice_ctrl(input logic [MCTRL_W-1:0] c,
                                                     input logic ovf);
    logic [WCTRL_W-1:0] r;
    r = c[WCTRL_W-1:0];
    if (KILL_ON_OVF && ovf) r[REG_WRITE_BIT] = 1'b0;
    return r;
  endfunction

  // Capture-side control slicing and overflow kill.
  always_comb begin
    ctrl_cap = slice_ctrl(ctrl_m, ovf_m);
  end

  assign pay_in = {mem_data_m, alu_out_m, reg_dst_m, ctrl_cap, ovf_m};

  pipe_skid_buf #(
    .WIDTH(PAY_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .in_valid_i (m_valid),
    .in_ready_o (m_ready),
    .in_data_i  (pay_in),
    .out_valid_o(w_valid),
    .out_ready_i(w_ready),
    .out_data_o (pay_out)
  );

  assign {mem_data_w, alu_out_w, reg_dst_w, ctrl_w, ovf_w} = pay_out;

endmodule
